branch_resolve_unit: RTL and testbench

Execute-stage branch resolution block and write-side partner of the branch target buffer. It compares each resolved branch/jump against the prediction carried down from fetch and issues a registered redirect and flush window on mismatch. Taken control transfers whose target the BTB does not already hold are queued in a small FIFO and drained into the BTB update port one per cycle.

---
 rtl/branch_resolve_unit_pkg.sv | 29 ++
 rtl/branch_resolve_unit_if.sv | 43 ++++
 rtl/branch_resolve_unit_update_fifo.sv | 78 +++++++
 rtl/branch_resolve_unit.sv | 127 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and build constants for the execute-stage branch resolution slice.
// Holds XLEN, the BTB geometry and the BRU queue/flush defaults.
package branch_resolve_unit_pkg;

  localparam int XLEN             = 32;
  localparam int BTB_ENTRIES      = 16;
  localparam int BTB_INDEX_W      = 4;
  localparam int BRU_FIFO_DEPTH   = 4;
  localparam int BRU_FLUSH_CYCLES = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } bru_update_t;

  // Next fetch address: the given destination when taken, else the fall-through PC.
  function automatic logic [XLEN-1:0] next_pc(input logic            take,
                                              input logic [XLEN-1:0] dest,
                                              input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] step;
    step = XLEN'(4);
    if (take) begin
      return dest;
    end else begin
      return pc + step;
    end
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage resolution bus: pipeline-side inputs, BTB update port, redirect/flush and perf outputs.
// master = pipeline/BTB side, slave = branch_resolve_unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W = XLEN
);

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_is_branch;
  logic              ex_is_jump;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_hit;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              btb_update_ready;
  logic              btb_update_enable;
  logic [ADDR_W-1:0] btb_pc_update;
  logic [ADDR_W-1:0] btb_target_update;
  logic              btb_is_branch_or_jump;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic              upd_full;
  logic [31:0]       perf_branches;
  logic [31:0]       perf_mispredicts;

  modport master (
    output ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
           ex_pred_hit, ex_pred_target, btb_update_ready,
    input  btb_update_enable, btb_pc_update, btb_target_update, btb_is_branch_or_jump,
           redirect_valid, redirect_pc, flush, upd_full, perf_branches, perf_mispredicts
  );

  modport slave (
    input  ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
           ex_pred_hit, ex_pred_target, btb_update_ready,
    output btb_update_enable, btb_pc_update, btb_target_update, btb_is_branch_or_jump,
           redirect_valid, redirect_pc, flush, upd_full, perf_branches, perf_mispredicts
  );

endinterface

// File: rtl/branch_resolve_unit_update_fifo.sv
// bru_update_fifo: circular {pc, target} queue feeding the BTB write port, one pop per cycle.
// A push on a full queue is kept only when a pop frees a slot in the same cycle.
module bru_update_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = BRU_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  bru_update_t data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output bru_update_t data_o,
  output logic        full_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  bru_update_t   mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q;
  logic          pop_s, push_s;

  assign pop_s  = (count_q != CNT_ZERO) & ready_i;
  assign push_s = push_i & ((count_q != CNT_FULL) | pop_s);

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
      full_q  <= 1'b0;
    end else begin
      if (push_s) tail_q <= tail_q + PTR_ONE;
      if (pop_s)  head_q <= head_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[tail_q] <= data_i;
  end

  // Head entry is masked to zero when the queue is empty.
  always_comb begin
    data_o = bru_update_t'({(2*XLEN){1'b0}});
    if (count_q != CNT_ZERO) begin
      data_o = mem_q[head_q];
    end else begin
      data_o = bru_update_t'({(2*XLEN){1'b0}});
    end
  end

  assign valid_o = (count_q != CNT_ZERO);
  assign full_o  = full_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX-stage control transfers, issues redirect/flush, feeds BTB updates.
// Optional build macro BRU_PERF_EN adds the branch/mispredict performance counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FIFO_DEPTH   = BRU_FIFO_DEPTH,
  parameter int FLUSH_CYCLES = BRU_FLUSH_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_unit_if.slave bru
);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] CNT_ONE    = 4'd1;

  logic [0:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            resolve_s, mispredict_s, enqueue_s;
  logic [XLEN-1:0] actual_s, pred_s;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;
  logic            fifo_valid_s, fifo_full_s;
  bru_update_t     push_data_s, head_s;

  // Wrong-path instructions arriving during recovery are invisible here.
  assign resolve_s    = bru.ex_valid & (bru.ex_is_branch | bru.ex_is_jump) & (state_q == ST_NORMAL);
  assign actual_s     = next_pc(bru.ex_taken, bru.ex_target, bru.ex_pc);
  assign pred_s       = next_pc(bru.ex_pred_hit, bru.ex_pred_target, bru.ex_pc);
  assign mispredict_s = resolve_s & (actual_s != pred_s);
  assign enqueue_s    = resolve_s & bru.ex_taken
                      & (~bru.ex_pred_hit | (bru.ex_pred_target != bru.ex_target));
  assign push_data_s  = '{pc: bru.ex_pc, target: bru.ex_target};

  // Recovery FSM: the counter tracks remaining flush cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (mispredict_s) begin
          state_d = ST_RECOVER;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = ST_NORMAL;
          cnt_d   = cnt_q;
        end
      end
      ST_RECOVER: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state plus the registered redirect/flush outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_NORMAL;
      cnt_q            <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {XLEN{1'b0}};
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= mispredict_s;
      redirect_pc_q    <= mispredict_s ? actual_s : {XLEN{1'b0}};
      flush_q          <= (state_d == ST_RECOVER);
    end
  end

  bru_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_update_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (enqueue_s),
    .data_i  (push_data_s),
    .ready_i (bru.btb_update_ready),
    .valid_o (fifo_valid_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s)
  );

  assign bru.btb_update_enable     = fifo_valid_s;
  assign bru.btb_is_branch_or_jump = fifo_valid_s;
  assign bru.btb_pc_update         = head_s.pc;
  assign bru.btb_target_update     = head_s.target;
  assign bru.upd_full              = fifo_full_s;
  assign bru.redirect_valid        = redirect_valid_q;
  assign bru.redirect_pc           = redirect_pc_q;
  assign bru.flush                 = flush_q;

`ifdef BRU_PERF_EN
  logic [31:0] perf_br_q, perf_mis_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_br_q  <= 32'd0;
      perf_mis_q <= 32'd0;
    end else begin
      if (resolve_s)    perf_br_q  <= perf_br_q + 32'd1;
      if (mispredict_s) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign bru.perf_branches    = perf_br_q;
  assign bru.perf_mispredicts = perf_mis_q;
`else
  assign bru.perf_branches    = 32'd0;
  assign bru.perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded random + directed bench for branch_resolve_unit.
// Reference model: redirect/update expectations computed from PC arithmetic and a bounded queue.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
  } upd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ADDR_W(XLEN)) bus ();

  branch_resolve_unit #(
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bru   (bus)
  );

  upd_t            exp_upd[$];
  logic [XLEN-1:0] exp_redir[$];
  int              n_cmp  = 0;
  int              n_fail = 0;
  int              model_occ = 0;
  int              rec = 0;
  logic [31:0]     exp_br = 32'd0;
  logic [31:0]     exp_mis = 32'd0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    exp_upd.delete();
    exp_redir.delete();
    model_occ = 0;
    rec       = 0;
    exp_br    = 32'd0;
    exp_mis   = 32'd0;
  endfunction

  // Scoreboard monitor: consumes redirects and BTB update handshakes as the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.redirect_valid) begin
        if (exp_redir.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_redirect: got pc 0x%0h, expected none", bus.redirect_pc);
        end else begin
          check("redirect_pc", bus.redirect_pc, exp_redir.pop_front());
        end
        check("flush_with_redirect", bus.flush, 1);
      end
      if (bus.btb_update_enable) begin
        check("btb_is_branch_or_jump", bus.btb_is_branch_or_jump, 1);
        if (bus.btb_update_ready) begin
          if (exp_upd.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_update: got {0x%0h,0x%0h}, expected none",
                     bus.btb_pc_update, bus.btb_target_update);
          end else begin
            check("btb_update", {bus.btb_pc_update, bus.btb_target_update}, exp_upd.pop_front());
          end
        end
      end else begin
        check("btb_idle_zero", {bus.btb_pc_update, bus.btb_target_update}, 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic isb, input logic isj,
                       input logic tk, input logic [XLEN-1:0] tgt, input logic hit,
                       input logic [XLEN-1:0] ptgt, input logic rdy);
    bit pop, mis;
    logic [XLEN-1:0] act, pred;
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_is_branch = isb; bus.ex_is_jump = isj;
    bus.ex_taken = tk; bus.ex_target = tgt; bus.ex_pred_hit = hit; bus.ex_pred_target = ptgt;
    bus.btb_update_ready = rdy;
    pop = (model_occ > 0) && rdy;
    mis = 1'b0;
    if (rec > 0) begin
      rec--;
    end else if (v && (isb || isj)) begin
      exp_br = exp_br + 32'd1;
      act  = tk  ? tgt  : pc + 32'd4;
      pred = hit ? ptgt : pc + 32'd4;
      if (act != pred) begin
        mis = 1'b1;
        exp_mis = exp_mis + 32'd1;
        rec = FC;
        exp_redir.push_back(act);
      end
      if (tk && (!hit || ptgt != tgt) && (model_occ < DEPTH || pop)) begin
        exp_upd.push_back('{pc: pc, tgt: tgt});
        model_occ++;
      end
    end
    if (pop) model_occ--;
    @(posedge clk);
    #1;
    check("redirect_valid", bus.redirect_valid, mis);
    check("flush", bus.flush, rec > 0);
    check("upd_full", bus.upd_full, model_occ == DEPTH);
    check("btb_update_enable", bus.btb_update_enable, model_occ != 0);
`ifdef BRU_PERF_EN
    check("perf_branches", bus.perf_branches, exp_br);
    check("perf_mispredicts", bus.perf_mispredicts, exp_mis);
`else
    check("perf_branches_tied", bus.perf_branches, 64'd0);
    check("perf_mispredicts_tied", bus.perf_mispredicts, 64'd0);
`endif
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic settle();
    for (int k = 0; k < 40 && (model_occ != 0 || rec != 0); k++) idle(1'b1);
    idle(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redirect_valid"}, bus.redirect_valid, 64'd0);
    check({tag, "_redirect_pc"}, bus.redirect_pc, 64'd0);
    check({tag, "_flush"}, bus.flush, 64'd0);
    check({tag, "_upd_full"}, bus.upd_full, 64'd0);
    check({tag, "_btb_enable"}, bus.btb_update_enable, 64'd0);
    check({tag, "_btb_pc"}, bus.btb_pc_update, 64'd0);
    check({tag, "_btb_target"}, bus.btb_target_update, 64'd0);
    check({tag, "_btb_is_bj"}, bus.btb_is_branch_or_jump, 64'd0);
    check({tag, "_perf_br"}, bus.perf_branches, 64'd0);
    check({tag, "_perf_mis"}, bus.perf_mispredicts, 64'd0);
  endtask

  initial begin
    logic [XLEN-1:0] pc, tgt, ptgt;
    logic            isb, isj, tk, hit;
    int              kind;

    bus.ex_valid = 1'b0; bus.ex_pc = 32'd0; bus.ex_is_branch = 1'b0; bus.ex_is_jump = 1'b0;
    bus.ex_taken = 1'b0; bus.ex_target = 32'd0; bus.ex_pred_hit = 1'b0; bus.ex_pred_target = 32'd0;
    bus.btb_update_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    idle(1'b1);

    // Unpredicted jump: redirect to 0x200, two flush cycles, update {0x100,0x200}.
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 1'b1);
    check("t1_redirect_pc", bus.redirect_pc, 32'h200);
    check("t1_btb_pc", bus.btb_pc_update, 32'h100);
    check("t1_btb_target", bus.btb_target_update, 32'h200);
    settle();

    // Correctly predicted taken branch: nothing happens.
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1);
    settle();
    // Predicted-taken branch that falls through: redirect to 0x44, no update.
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
    check("t3_redirect_pc", bus.redirect_pc, 32'h44);
    settle();
    // Fall-through wraps to zero at the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1);
    check("wrap_redirect_pc", bus.redirect_pc, 32'h0);
    settle();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1);
    settle();

    // Stalled BTB port: five mispredicted jumps, fifth dropped, then ordered drain.
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 32'h1000 + 32'(j * 16), 1'b0, 1'b1, 1'b1, 32'h2000 + 32'(j * 16), 1'b0, 32'd0, 1'b0);
      idle(1'b0);
      idle(1'b0);
    end
    check("t4_upd_full", bus.upd_full, 1);
    check("t4_queued", exp_upd.size(), DEPTH);
    for (int j = 0; j < 6; j++) idle(1'b1);
    check("t4_drained", exp_upd.size(), 0);

    // Reset during flush with two queued updates.
    settle();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 32'h310, 1'b0, 1'b1, 1'b1, 32'h410, 1'b0, 32'd0, 1'b0);
    check("t6_pre_flush", bus.flush, 1);
    check("t6_pre_queue", model_occ, 2);
    bus.ex_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_release");

    // Branches inside the flush window are ignored.
    drive(1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h604, 1'b1, 1'b0, 1'b1, 32'h800, 1'b0, 32'd0, 1'b1);
    idle(1'b1);
`ifdef BRU_PERF_EN
    check("t5_perf_branches", bus.perf_branches, 1);
    check("t5_perf_mispredicts", bus.perf_mispredicts, 1);
`else
    check("t5_perf_branches", bus.perf_branches, 0);
    check("t5_perf_mispredicts", bus.perf_mispredicts, 0);
`endif
    settle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 3));
      isb  = (kind == 1) || (kind == 2);
      isj  = (kind == 3);
      pc   = $urandom & 32'h0000_0FFC;
      tgt  = $urandom & 32'h0000_0FFC;
      tk   = isj ? 1'b1 : 1'($urandom_range(0, 1));
      hit  = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 2) != 0) ? tgt : ($urandom & 32'h0000_0FFC);
      drive(1'($urandom_range(0, 4) != 0), pc, isb, isj, tk, tgt, hit, ptgt,
            1'($urandom_range(0, 1)));
    end

    settle();
    idle(1'b1);
    check("end_redirects_consumed", exp_redir.size(), 0);
    check("end_updates_consumed", exp_upd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
